// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry circular reorder buffer for the Tomasulo core.
// Allocates rename tags at issue, captures CDB results, and retires one
// instruction per cycle in program order. Retirement drives the register
// file commit port, releases stores to the LSB, and raises the pipeline
// flush when a mispredicted branch reaches the head.
module reorder_buffer #(
    parameter int ROB_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  issue_valid,
    input  logic [1:0]            issue_type,
    input  logic [4:0]            issue_rd,
    output logic [ROB_ADDR_W-1:0] issue_id,
    output logic                  rob_full,
    input  logic                  cdb_valid,
    input  logic [ROB_ADDR_W-1:0] cdb_id,
    input  logic [31:0]           cdb_value,
    input  logic                  cdb_mispredict,
    input  logic [31:0]           cdb_target,
    output logic                  register_update_flag,
    output logic [4:0]            register_commit_dest,
    output logic [31:0]           register_commit_value,
    output logic [ROB_ADDR_W-1:0] rename_of_commit_ins,
    output logic                  store_commit_flag,
    output logic [ROB_ADDR_W-1:0] store_commit_id,
    output logic                  flush_flag,
    output logic [31:0]           flush_pc
);

    localparam int                  DEPTH    = 1 << ROB_ADDR_W;
    localparam logic [ROB_ADDR_W:0] C_FULL   = (ROB_ADDR_W + 1)'(DEPTH);
    localparam logic [1:0]          T_REG    = 2'd0;
    localparam logic [1:0]          T_STORE  = 2'd1;
    localparam logic [1:0]          T_BRANCH = 2'd2;

    logic [DEPTH-1:0]      r_busy;
    logic [DEPTH-1:0]      r_ready;
    logic [DEPTH-1:0]      r_mis;
    logic [1:0]            r_type   [DEPTH];
    logic [4:0]            r_rd     [DEPTH];
    logic [31:0]           r_value  [DEPTH];
    logic [31:0]           r_target [DEPTH];
    logic [ROB_ADDR_W-1:0] r_head;
    logic [ROB_ADDR_W-1:0] r_tail;
    logic [ROB_ADDR_W:0]   r_count;

    logic       w_commit;
    logic       w_flush;
    logic       w_issue;
    logic       w_cdb_hit;
    logic [1:0] w_head_type;
    logic [1:0] w_issue_type;

    // Commit and full decisions all use pre-edge state; a flush swallows
    // any issue or CDB write arriving on the same edge.
    assign w_head_type  = r_type[r_head];
    assign w_commit     = rdy && r_busy[r_head] && r_ready[r_head];
    assign w_flush      = w_commit && (w_head_type == T_BRANCH) && r_mis[r_head];
    assign w_issue      = rdy && issue_valid && (r_count != C_FULL) && !w_flush;
    assign w_cdb_hit    = rdy && cdb_valid && r_busy[cdb_id] && !w_flush;
    assign w_issue_type = (issue_type == 2'd3) ? T_REG : issue_type;

    assign issue_id = r_tail;
    assign rob_full = (r_count == C_FULL);

    // Occupancy bookkeeping: busy/ready flags, head/tail pointers and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= '0;
            r_ready <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_busy  <= '0;
            r_ready <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_cdb_hit) begin
                r_ready[cdb_id] <= 1'b1;
            end
            if (w_commit) begin
                r_busy[r_head]  <= 1'b0;
                r_ready[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_issue) begin
                r_busy[r_tail]  <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_issue, w_commit})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload; only read while the entry is busy and ready, so no reset.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_type[r_tail] <= w_issue_type;
            r_rd[r_tail]   <= issue_rd;
            r_mis[r_tail]  <= 1'b0;
        end
        if (w_cdb_hit) begin
            r_value[cdb_id]  <= cdb_value;
            r_mis[cdb_id]    <= cdb_mispredict;
            r_target[cdb_id] <= cdb_target;
        end
    end

    // Registered commit outputs; flags pulse for one cycle, payloads hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            register_update_flag  <= 1'b0;
            register_commit_dest  <= '0;
            register_commit_value <= '0;
            rename_of_commit_ins  <= '0;
            store_commit_flag     <= 1'b0;
            store_commit_id       <= '0;
            flush_flag            <= 1'b0;
            flush_pc              <= '0;
        end else begin
            register_update_flag <= 1'b0;
            store_commit_flag    <= 1'b0;
            flush_flag           <= 1'b0;
            if (w_commit) begin
                if ((w_head_type == T_REG || w_head_type == T_BRANCH) && r_rd[r_head] != 5'd0) begin
                    register_update_flag  <= 1'b1;
                    register_commit_dest  <= r_rd[r_head];
                    register_commit_value <= r_value[r_head];
                    rename_of_commit_ins  <= r_head;
                end
                if (w_head_type == T_STORE) begin
                    store_commit_flag <= 1'b1;
                    store_commit_id   <= r_head;
                end
                if (w_flush) begin
                    flush_flag <= 1'b1;
                    flush_pc   <= r_target[r_head];
                end
            end
        end
    end

endmodule
